// File: rtl/phy_rx_link_ctrl.sv
// phy_rx_link_ctrl: two-lane COM lock, alignment and loss-of-signal link FSM; PHY_RX_LINK_CTRL_ERRCNT_EN enables err_cnt
module phy_rx_link_ctrl #(
  parameter int COM_COUNT     = 4,
  parameter int LOSS_MAX      = 8,
  parameter int ALIGN_TIMEOUT = 16
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic [7:0] data_0,
  input  logic       valid_0,
  input  logic [7:0] data_1,
  input  logic       valid_1,
  output logic       en_0,
  output logic       en_1,
  output logic       link_up,
  output logic [1:0] state,
  output logic [1:0] sync,
  output logic [7:0] err_cnt
);
  localparam int CW = $clog2(COM_COUNT + 1);
  localparam int LW = $clog2(LOSS_MAX + 1);
  localparam int AW = $clog2(ALIGN_TIMEOUT);
  typedef enum logic [1:0] {S_RESET, S_TRAIN, S_ALIGN, S_ACTIVE} state_t;
  state_t st;
  logic [CW-1:0] com_0, com_1;
  logic [LW-1:0] miss_0, miss_1;
  logic [AW-1:0] align_cnt;
  logic is_com_0, is_com_1, first_0, first_1, timeout, loss;
  always_comb begin
    is_com_0 = valid_0 && data_0 == 8'hBC;
    is_com_1 = valid_1 && data_1 == 8'hBC;
    first_0  = valid_0 && data_0 != 8'hBC;
    first_1  = valid_1 && data_1 != 8'hBC;
    timeout  = align_cnt == AW'(ALIGN_TIMEOUT - 1);
    loss     = (!valid_0 && miss_0 == LW'(LOSS_MAX - 1)) || (!valid_1 && miss_1 == LW'(LOSS_MAX - 1));
  end
  assign sync    = {com_1 == CW'(COM_COUNT), com_0 == CW'(COM_COUNT)};
  assign state   = st;
  assign en_0    = st == S_ACTIVE;
  assign en_1    = st == S_ACTIVE;
  assign link_up = st == S_ACTIVE;
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      st        <= S_RESET;
      com_0     <= '0;
      com_1     <= '0;
      miss_0    <= '0;
      miss_1    <= '0;
      align_cnt <= '0;
    end else begin
      case (st)
        S_RESET: begin
          st    <= S_TRAIN;
          com_0 <= '0;
          com_1 <= '0;
        end
        S_TRAIN: begin
          if (valid_0) com_0 <= is_com_0 ? (sync[0] ? com_0 : com_0 + CW'(1)) : '0;
          if (valid_1) com_1 <= is_com_1 ? (sync[1] ? com_1 : com_1 + CW'(1)) : '0;
          if (&sync) begin
            st        <= S_ALIGN;
            align_cnt <= '0;
          end
        end
        S_ALIGN: begin
          if (first_0 && first_1) begin
            st     <= S_ACTIVE;
            miss_0 <= '0;
            miss_1 <= '0;
          end else if (first_0 || first_1 || timeout) begin
            st    <= S_TRAIN;
            com_0 <= '0;
            com_1 <= '0;
          end else begin
            align_cnt <= align_cnt + AW'(1);
          end
        end
        default: begin
          miss_0 <= valid_0 ? '0 : miss_0 + LW'(1);
          miss_1 <= valid_1 ? '0 : miss_1 + LW'(1);
          if (loss) begin
            st    <= S_TRAIN;
            com_0 <= '0;
            com_1 <= '0;
          end
        end
      endcase
    end
  end
`ifdef PHY_RX_LINK_CTRL_ERRCNT_EN
  logic err_evt;
  assign err_evt = st == S_ALIGN && !(first_0 && first_1) && (first_0 || first_1 || timeout);
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) err_cnt <= '0;
    else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'h00;
`endif
endmodule
